// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for the ALSU multiplexed 7-segment display interface:
// cathode patterns, anode one-hots, digit-kind and scan FSM encodings.
package seg7_scan_decoder_pkg;

  // Cathode patterns {a,b,c,d,e,f,g}, active-high, bit6 = segment a
  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_B    = 7'b0011111;
  localparam logic [6:0] SEG_C    = 7'b1001110;
  localparam logic [6:0] SEG_D    = 7'b0111101;
  localparam logic [6:0] SEG_E    = 7'b1001111;
  localparam logic [6:0] SEG_F    = 7'b1000111;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  // Anode one-hots, digit0 is the least significant digit
  localparam logic [3:0] AN_DIG0 = 4'b0001;
  localparam logic [3:0] AN_DIG1 = 4'b0010;
  localparam logic [3:0] AN_DIG2 = 4'b0100;
  localparam logic [3:0] AN_DIG3 = 4'b1000;

  typedef enum logic [1:0] {
    KIND_HEX  = 2'd0,
    KIND_DASH = 2'd1,
    KIND_BAD  = 2'd2
  } digit_kind_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } scan_state_t;

  // True when exactly one bit of the anode vector is set
  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational cathode pattern classifier: hex digit, dash, or unrecognised.
// Dash and unrecognised patterns report a zero nibble.
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0]  cathode,
  output digit_kind_t kind,
  output logic [3:0]  nibble
);

  // Map the segment pattern to its kind and hex value
  always_comb begin
    kind   = KIND_HEX;
    nibble = 4'h0;
    case (cathode)
      SEG_0:    nibble = 4'h0;
      SEG_1:    nibble = 4'h1;
      SEG_2:    nibble = 4'h2;
      SEG_3:    nibble = 4'h3;
      SEG_4:    nibble = 4'h4;
      SEG_5:    nibble = 4'h5;
      SEG_6:    nibble = 4'h6;
      SEG_7:    nibble = 4'h7;
      SEG_8:    nibble = 4'h8;
      SEG_9:    nibble = 4'h9;
      SEG_A:    nibble = 4'hA;
      SEG_B:    nibble = 4'hB;
      SEG_C:    nibble = 4'hC;
      SEG_D:    nibble = 4'hD;
      SEG_E:    nibble = 4'hE;
      SEG_F:    nibble = 4'hF;
      SEG_DASH: kind   = KIND_DASH;
      default:  kind   = KIND_BAD;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for the ALSU multiplexed 7-segment scan: samples anode/cathode,
// commits stable digits, rebuilds 4-digit frames and recovers the 6-bit result.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 1,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  output logic        frame_valid,
  output logic [15:0] frame_digits,
  output logic [3:0]  frame_dash,
  output logic [3:0]  frame_bad,
  output logic [5:0]  frame_value,
  output logic        value_ok,
  output logic        err_frame,
  output logic        scan_err,
  output logic        scan_stall
);

  // Counter saturates one past the largest legal STABLE_CYCLES so a long dwell never re-commits
  localparam logic [4:0]  STABLE_LIM = 5'(STABLE_CYCLES);
  localparam logic [4:0]  STABLE_SAT = 5'd16;
  localparam logic [15:0] TO_LIM     = 16'(TIMEOUT);

  logic [3:0]  anode_r;
  logic [6:0]  cathode_r;
  logic [4:0]  stab_cnt_r;
  logic [15:0] to_cnt_r;
  scan_state_t state_r, state_nxt_s;
  logic [1:0]  expect_r, expect_nxt_s;
  logic [1:0]  last_r, last_nxt_s;
  logic [15:0] buf_digits_r;
  logic [3:0]  buf_dash_r, buf_bad_r;
  logic        done_r;

  logic        dwell_done_s, commit_s, bad_anode_s, timeout_s, eff_idle_s;
  logic [1:0]  dig_idx_s;
  digit_kind_t kind_s;
  logic [3:0]  nibble_s;
  logic        is_dash_s, is_bad_s;
  logic        start_s, in_seq_s, out_of_order_s, restart_s;
  logic        store_s, clear_s, done_s, seq_err_s;
  logic        hex0_s, hex1_s, hex2_s, hex3_s;
  logic        value_ok_nxt_s, err_frame_nxt_s;

  seg7_pattern_decode u_decode (
    .cathode (cathode_r),
    .kind    (kind_s),
    .nibble  (nibble_s)
  );

  // Input sampling and dwell-length counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_r    <= 4'd0;
      cathode_r  <= 7'd0;
      stab_cnt_r <= 5'd0;
    end else begin
      anode_r   <= anode;
      cathode_r <= cathode;
      if ({anode, cathode} != {anode_r, cathode_r}) begin
        stab_cnt_r <= 5'd1;
      end else if (stab_cnt_r != STABLE_SAT) begin
        stab_cnt_r <= stab_cnt_r + 5'd1;
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  assign dwell_done_s = (stab_cnt_r == STABLE_LIM);
  assign commit_s     = dwell_done_s && is_one_hot4(anode_r);
  assign bad_anode_s  = dwell_done_s && !is_one_hot4(anode_r);
  assign is_dash_s    = (kind_s == KIND_DASH);
  assign is_bad_s     = (kind_s == KIND_BAD);

  // Digit index of the sampled one-hot anode
  always_comb begin
    dig_idx_s = 2'd0;
    case (anode_r)
      AN_DIG0: dig_idx_s = 2'd0;
      AN_DIG1: dig_idx_s = 2'd1;
      AN_DIG2: dig_idx_s = 2'd2;
      AN_DIG3: dig_idx_s = 2'd3;
      default: dig_idx_s = 2'd0;
    endcase
  end

  // Cycles since the last commit, saturating at the stall threshold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= 16'd0;
    end else if (commit_s) begin
      to_cnt_r <= 16'd0;
    end else if (!timeout_s) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  assign timeout_s  = (to_cnt_r == TO_LIM);
  // A timed-out collection behaves as IDLE, so only a digit0 commit can restart it
  assign eff_idle_s = (state_r == ST_IDLE) || timeout_s;

  assign start_s        = commit_s && eff_idle_s && (dig_idx_s == 2'd0);
  assign in_seq_s       = commit_s && !eff_idle_s && (dig_idx_s == expect_r);
  assign out_of_order_s = commit_s && !eff_idle_s && (dig_idx_s != expect_r) && (dig_idx_s != last_r);
  assign restart_s      = out_of_order_s && (dig_idx_s == 2'd0);

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      expect_r <= 2'd0;
      last_r   <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      expect_r <= expect_nxt_s;
      last_r   <= last_nxt_s;
    end
  end

  // Scan FSM next-state: follow digits 0..3 in order, restart on digit0, drop otherwise
  always_comb begin
    state_nxt_s  = state_r;
    expect_nxt_s = expect_r;
    last_nxt_s   = last_r;
    if (start_s || restart_s) begin
      state_nxt_s  = ST_COLLECT;
      expect_nxt_s = 2'd1;
      last_nxt_s   = 2'd0;
    end else if (in_seq_s) begin
      last_nxt_s = expect_r;
      if (expect_r == 2'd3) begin
        state_nxt_s  = ST_IDLE;
        expect_nxt_s = 2'd0;
      end else begin
        state_nxt_s  = ST_COLLECT;
        expect_nxt_s = expect_r + 2'd1;
      end
    end else if (out_of_order_s || eff_idle_s) begin
      state_nxt_s  = ST_IDLE;
      expect_nxt_s = 2'd0;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Scan FSM outputs: buffer writes, frame completion and ordering errors
  always_comb begin
    store_s   = start_s || restart_s || in_seq_s;
    clear_s   = start_s || restart_s;
    done_s    = in_seq_s && (expect_r == 2'd3);
    seq_err_s = out_of_order_s;
  end

  // Frame assembly buffer; a fresh digit0 discards any partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_digits_r <= 16'd0;
      buf_dash_r   <= 4'd0;
      buf_bad_r    <= 4'd0;
      done_r       <= 1'b0;
    end else begin
      done_r <= done_s;
      if (store_s && clear_s) begin
        buf_digits_r <= {12'd0, nibble_s};
        buf_dash_r   <= {3'd0, is_dash_s};
        buf_bad_r    <= {3'd0, is_bad_s};
      end else if (store_s) begin
        buf_digits_r[{dig_idx_s, 2'b00} +: 4] <= nibble_s;
        buf_dash_r[dig_idx_s]                 <= is_dash_s;
        buf_bad_r[dig_idx_s]                  <= is_bad_s;
      end else begin
        buf_digits_r <= buf_digits_r;
      end
    end
  end

  // Derived frame flags computed from the completed buffer
  always_comb begin
    hex0_s = !buf_dash_r[0] && !buf_bad_r[0];
    hex1_s = !buf_dash_r[1] && !buf_bad_r[1];
    hex2_s = !buf_dash_r[2] && !buf_bad_r[2];
    hex3_s = !buf_dash_r[3] && !buf_bad_r[3];
    value_ok_nxt_s  = hex0_s && hex1_s && (buf_digits_r[7:4] <= 4'd3);
    err_frame_nxt_s = hex0_s && (buf_digits_r[3:0] == 4'h4) &&
                      buf_dash_r[1] &&
                      hex2_s && (buf_digits_r[11:8] == 4'h4) &&
                      hex3_s && (buf_digits_r[15:12] == 4'hE);
  end

  // Registered frame outputs, error pulse and sticky stall flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid  <= 1'b0;
      frame_digits <= 16'd0;
      frame_dash   <= 4'd0;
      frame_bad    <= 4'd0;
      frame_value  <= 6'd0;
      value_ok     <= 1'b0;
      err_frame    <= 1'b0;
      scan_err     <= 1'b0;
      scan_stall   <= 1'b0;
    end else begin
      frame_valid <= done_r;
      scan_err    <= seq_err_s || bad_anode_s;
      if (done_r) begin
        frame_digits <= buf_digits_r;
        frame_dash   <= buf_dash_r;
        frame_bad    <= buf_bad_r;
        frame_value  <= {buf_digits_r[5:4], buf_digits_r[3:0]};
        value_ok     <= value_ok_nxt_s;
        err_frame    <= err_frame_nxt_s;
        scan_stall   <= 1'b0;
      end else if (timeout_s) begin
        scan_stall <= 1'b1;
      end else begin
        scan_stall <= scan_stall;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a per-instance frame scoreboard.
// Instance A uses STABLE_CYCLES=1, instance B uses STABLE_CYCLES=3.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  anode_a, anode_b;
  logic [6:0]  cathode_a, cathode_b;
  logic        frame_valid_a, frame_valid_b;
  logic [15:0] frame_digits_a, frame_digits_b;
  logic [3:0]  frame_dash_a, frame_dash_b, frame_bad_a, frame_bad_b;
  logic [5:0]  frame_value_a, frame_value_b;
  logic        value_ok_a, value_ok_b, err_frame_a, err_frame_b;
  logic        scan_err_a, scan_err_b, scan_stall_a, scan_stall_b;

  seg7_scan_decoder #(.STABLE_CYCLES(1), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst), .anode(anode_a), .cathode(cathode_a),
    .frame_valid(frame_valid_a), .frame_digits(frame_digits_a),
    .frame_dash(frame_dash_a), .frame_bad(frame_bad_a),
    .frame_value(frame_value_a), .value_ok(value_ok_a),
    .err_frame(err_frame_a), .scan_err(scan_err_a), .scan_stall(scan_stall_a)
  );

  seg7_scan_decoder #(.STABLE_CYCLES(3), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .anode(anode_b), .cathode(cathode_b),
    .frame_valid(frame_valid_b), .frame_digits(frame_digits_b),
    .frame_dash(frame_dash_b), .frame_bad(frame_bad_b),
    .frame_value(frame_value_b), .value_ok(value_ok_b),
    .err_frame(err_frame_b), .scan_err(scan_err_b), .scan_stall(scan_stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int frames_a, frames_b;
  int serr_a;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [6:0]  seg_tab [16];

  // Expected frame record: {digits, dash, bad, value, value_ok, err_frame}
  function automatic logic [31:0] pack_exp(input logic [15:0] d, input logic [3:0] dash,
                                           input logic [3:0] bad, input logic [5:0] v,
                                           input logic ok, input logic err);
    return {d, dash, bad, v, ok, err};
  endfunction

  // One clock cycle; outputs are inspected on the falling edge
  task automatic tick();
    logic [31:0] obs;
    logic [31:0] exp_v;
    @(negedge clk);
    if (rst) begin
      serr_a += int'(scan_err_a);
      if (frame_valid_a) begin
        frames_a++;
        obs = {frame_digits_a, frame_dash_a, frame_bad_a, frame_value_a, value_ok_a, err_frame_a};
        checks++;
        assert (q_a.size() != 0)
        else begin errors++; $error("FAIL frame_a_unexpected observed %h expected none", obs); end
        if (q_a.size() != 0) begin
          exp_v = q_a.pop_front();
          checks++;
          assert (obs === exp_v)
          else begin errors++; $error("FAIL frame_a observed %h expected %h", obs, exp_v); end
        end
      end
      if (frame_valid_b) begin
        frames_b++;
        obs = {frame_digits_b, frame_dash_b, frame_bad_b, frame_value_b, value_ok_b, err_frame_b};
        checks++;
        assert (q_b.size() != 0)
        else begin errors++; $error("FAIL frame_b_unexpected observed %h expected none", obs); end
        if (q_b.size() != 0) begin
          exp_v = q_b.pop_front();
          checks++;
          assert (obs === exp_v)
          else begin errors++; $error("FAIL frame_b observed %h expected %h", obs, exp_v); end
        end
      end
    end
  endtask

  task automatic set_a(input int idx, input logic [6:0] cath);
    logic [3:0] one;
    one       = 4'b0001;
    anode_a   = one << idx;
    cathode_a = cath;
  endtask

  task automatic set_b(input int idx, input logic [6:0] cath);
    logic [3:0] one;
    one       = 4'b0001;
    anode_b   = one << idx;
    cathode_b = cath;
  endtask

  task automatic scan_a(input logic [6:0] c0, input logic [6:0] c1,
                        input logic [6:0] c2, input logic [6:0] c3, input int dwell);
    set_a(0, c0); repeat (dwell) tick();
    set_a(1, c1); repeat (dwell) tick();
    set_a(2, c2); repeat (dwell) tick();
    set_a(3, c3); repeat (dwell) tick();
  endtask

  task automatic wait_frame_a(input int start, input int budget);
    int n;
    n = 0;
    while (frames_a == start && n < budget) begin tick(); n++; end
    checks++;
    assert (frames_a == start + 1)
    else begin errors++; $error("FAIL wait_frame_a frames %0d expected %0d", frames_a, start + 1); end
  endtask

  task automatic wait_frame_b(input int start, input int budget);
    int n;
    n = 0;
    while (frames_b == start && n < budget) begin tick(); n++; end
    checks++;
    assert (frames_b == start + 1)
    else begin errors++; $error("FAIL wait_frame_b frames %0d expected %0d", frames_b, start + 1); end
  endtask

  initial begin
    int start;
    int ebase;
    logic [3:0] n0, n1, n2, n3;
    logic [34:0] all_a;
    checks = 0; errors = 0; frames_a = 0; frames_b = 0; serr_a = 0;
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    anode_a = 4'd0; cathode_a = 7'd0; anode_b = 4'd0; cathode_b = 7'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();

    // Reset state: every output low
    all_a = {frame_valid_a, frame_digits_a, frame_dash_a, frame_bad_a, frame_value_a,
             value_ok_a, err_frame_a, scan_err_a, scan_stall_a};
    checks++;
    assert (all_a === 35'd0)
    else begin errors++; $error("FAIL reset_outputs observed %h expected 0", all_a); end
    rst = 1'b1;
    repeat (3) tick();

    // 0x2B frame with latency check on the digit3 commit
    q_a.push_back(pack_exp(16'h002B, 4'b0000, 4'b0000, 6'h2B, 1'b1, 1'b0));
    start = frames_a;
    set_a(0, 7'b0011111); repeat (2) tick();
    set_a(1, 7'b1101101); repeat (2) tick();
    set_a(2, 7'b1111110); repeat (2) tick();
    set_a(3, 7'b1111110);
    repeat (2) tick();
    checks++;
    assert (frame_valid_a === 1'b0)
    else begin errors++; $error("FAIL latency_early observed %b expected 0", frame_valid_a); end
    tick();
    checks++;
    assert (frame_valid_a === 1'b1)
    else begin errors++; $error("FAIL latency_edge observed %b expected 1", frame_valid_a); end
    tick();
    checks++;
    assert (frame_valid_a === 1'b0)
    else begin errors++; $error("FAIL pulse_width observed %b expected 0", frame_valid_a); end
    checks++;
    assert (frames_a == start + 1)
    else begin errors++; $error("FAIL frame_2b_count observed %0d expected %0d", frames_a, start + 1); end

    // 4-4E invalid-opcode frame
    q_a.push_back(pack_exp(16'hE404, 4'b0010, 4'b0000, 6'h04, 1'b0, 1'b1));
    start = frames_a;
    scan_a(7'b0110011, 7'b0000001, 7'b0110011, 7'b1001111, 2);
    wait_frame_a(start, 10);

    // Out-of-order digit, then a non-one-hot anode, then a clean frame
    start = frames_a;
    ebase = serr_a;
    set_a(0, seg_tab[1]); repeat (2) tick();
    set_a(2, seg_tab[2]); repeat (3) tick();
    checks++;
    assert (serr_a - ebase == 1)
    else begin errors++; $error("FAIL scan_err_order observed %0d expected 1", serr_a - ebase); end
    anode_a = 4'b0011; cathode_a = seg_tab[5];
    repeat (5) tick();
    checks++;
    assert (serr_a - ebase == 2)
    else begin errors++; $error("FAIL scan_err_anode observed %0d expected 2", serr_a - ebase); end
    checks++;
    assert (frames_a == start)
    else begin errors++; $error("FAIL no_frame_on_err observed %0d expected %0d", frames_a, start); end
    q_a.push_back(pack_exp(16'h3210, 4'b0000, 4'b0000, 6'h10, 1'b1, 1'b0));
    scan_a(seg_tab[0], seg_tab[1], seg_tab[2], seg_tab[3], 2);
    wait_frame_a(start, 10);

    // Reset in the middle of a frame
    set_a(0, seg_tab[7]); repeat (2) tick();
    set_a(1, seg_tab[8]); repeat (2) tick();
    rst = 1'b0;
    tick();
    all_a = {frame_valid_a, frame_digits_a, frame_dash_a, frame_bad_a, frame_value_a,
             value_ok_a, err_frame_a, scan_err_a, scan_stall_a};
    checks++;
    assert (all_a === 35'd0)
    else begin errors++; $error("FAIL midframe_reset observed %h expected 0", all_a); end
    rst = 1'b1;
    start = frames_a;
    tick();
    set_a(2, seg_tab[9]); repeat (2) tick();
    set_a(3, seg_tab[10]); repeat (6) tick();
    checks++;
    assert (frames_a == start)
    else begin errors++; $error("FAIL partial_after_reset observed %0d expected %0d", frames_a, start); end
    q_a.push_back(pack_exp(16'h003F, 4'b0000, 4'b0000, 6'h3F, 1'b1, 1'b0));
    scan_a(seg_tab[15], seg_tab[3], seg_tab[0], seg_tab[0], 2);
    wait_frame_a(start, 10);

    // Random hex frames
    for (int i = 0; i < 4; i++) begin
      n0 = 4'($urandom_range(15, 0));
      n1 = 4'($urandom_range(15, 0));
      n2 = 4'($urandom_range(15, 0));
      n3 = 4'($urandom_range(15, 0));
      q_a.push_back(pack_exp({n3, n2, n1, n0}, 4'b0000, 4'b0000, {n1[1:0], n0},
                             (n1 <= 4'd3), 1'b0));
      start = frames_a;
      scan_a(seg_tab[n0], seg_tab[n1], seg_tab[n2], seg_tab[n3], 2);
      wait_frame_a(start, 10);
    end

    // Stall: a single digit held far longer than the timeout
    set_a(0, seg_tab[8]);
    repeat (60) tick();
    checks++;
    assert (scan_stall_a === 1'b0)
    else begin errors++; $error("FAIL stall_early observed %b expected 0", scan_stall_a); end
    repeat (40) tick();
    checks++;
    assert (scan_stall_a === 1'b1)
    else begin errors++; $error("FAIL stall_set observed %b expected 1", scan_stall_a); end
    q_a.push_back(pack_exp(16'h1765, 4'b0000, 4'b0000, 6'h25, 1'b0, 1'b0));
    start = frames_a;
    scan_a(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[1], 2);
    wait_frame_a(start, 10);
    checks++;
    assert (scan_stall_a === 1'b0)
    else begin errors++; $error("FAIL stall_clear observed %b expected 0", scan_stall_a); end

    // STABLE_CYCLES=3: unrecognised digit0 and a one-cycle glitch on digit1
    q_b.push_back(pack_exp(16'h3210, 4'b0000, 4'b0001, 6'h10, 1'b0, 1'b0));
    start = frames_b;
    set_b(0, 7'b1010101); repeat (3) tick();
    set_b(1, seg_tab[1]); tick();
    set_b(1, seg_tab[8]); tick();
    set_b(1, seg_tab[1]); repeat (3) tick();
    set_b(2, seg_tab[2]); repeat (3) tick();
    set_b(3, seg_tab[3]); repeat (3) tick();
    wait_frame_b(start, 12);

    repeat (4) tick();
    checks++;
    assert (q_a.size() == 0)
    else begin errors++; $error("FAIL queue_a_left observed %0d expected 0", q_a.size()); end
    checks++;
    assert (q_b.size() == 0)
    else begin errors++; $error("FAIL queue_b_left observed %0d expected 0", q_b.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
